accumulator32_seq: RTL

- Sequential accumulation stage directly downstream of the 32-bit carry-select adder.
- Registers each adder result and feeds it back as one operand.
- Sums a block of NSAMP input words, tracks carry-out overflow, and presents the block total through a valid/ready output handshake.
- Sits between the operand source and the result consumer in the arithmetic lab datapath.

---
 rtl/accumulator32_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/accumulator32_seq.sv
// accumulator32_seq: sums a block of NSAMP 32-bit words through an internal
// carry-select adder and presents the block total on a valid/ready output.
// Optional build macro: SATURATE_EN clamps the accumulator to all ones on the
// first adder carry-out of a block. Without it the sum wraps modulo 2^32.
// The sticky carry reports overflow in both builds.

// carry_select_adder32: 8 blocks of 4 bits. Each block precomputes both carry
// hypotheses and the incoming block carry selects one of them.
module carry_select_adder32 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        carryout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar b = 0; b < 8; b++) begin : g_blk
    logic [4:0] r0;
    logic [4:0] r1;

    assign r0             = {1'b0, in1[4*b+3:4*b]} + {1'b0, in2[4*b+3:4*b]};
    assign r1             = r0 + 5'd1;
    assign sum[4*b+3:4*b] = c[b] ? r1[3:0] : r0[3:0];
    assign c[b+1]         = c[b] ? r1[4]   : r0[4];
  end

  assign carryout = c[8];

endmodule

module accumulator32_seq #(
  parameter int NSAMP = 8,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum,
  output logic          out_carry,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(NSAMP);

  state_t        state, state_next;
  logic [31:0]   acc, acc_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          sticky, sticky_next;
  logic [31:0]   add_sum;
  logic          add_cout;
  logic          accept;

  carry_select_adder32 u_adder (
    .in1      (acc),
    .in2      (in_data),
    .cin      (1'b0),
    .sum      (add_sum),
    .carryout (add_cout)
  );

  // in_ready is gated by reset so it drops immediately, not only once state settles.
  assign in_ready  = (state != DONE) & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == ACCUM);
  assign out_sum   = acc;
  assign out_carry = sticky;
  assign out_count = cnt;

  // Next-state and datapath update; clear overrides accept and output handshake.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    cnt_next    = cnt;
    sticky_next = sticky;
    if (clear) begin
      state_next  = IDLE;
      acc_next    = '0;
      cnt_next    = '0;
      sticky_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // First word of a block: accumulator is treated as zero, no carry possible.
            acc_next    = in_data;
            cnt_next    = CW'(1);
            sticky_next = 1'b0;
            state_next  = (NSAMP == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef SATURATE_EN
            acc_next = add_cout ? '1 : add_sum;
`else
            acc_next = add_sum;
`endif
            sticky_next = sticky | add_cout;
            cnt_next    = cnt + CW'(1);
            if (cnt_next == LAST) state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_next    = '0;
            cnt_next    = '0;
            sticky_next = 1'b0;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      sticky <= sticky_next;
    end
  end

endmodule
